// File: rtl/req_encoder_8to3_if.sv
// ---------------------------------------------------------------------------
// req_encoder_8to3_if
//   Bundles the request/clear inputs, the valid/ready code handshake and the
//   status outputs of req_encoder_8to3.
//   master : encoder side. It samples req/clr/ready and drives y/valid/pend/ovf/busy.
//   slave  : source/consumer side. It drives req/clr/ready and observes the rest.
//   Signals:
//     req   [7:0]  request lines, 1 = set pending bit
//     clr   [7:0]  per-bit clear of pending flags
//     ready        consumer accepts y this cycle when valid=1
//     y     [2:0]  encoded index of the presented request
//     valid        y holds a valid index
//     pend  [7:0]  current pending flags
//     ovf          sticky overflow: a request hit an already-pending bit
//     busy         |pend | valid
// ---------------------------------------------------------------------------
interface req_encoder_8to3_if;
   logic [7:0] req;
   logic [7:0] clr;
   logic       ready;
   logic [2:0] y;
   logic       valid;
   logic [7:0] pend;
   logic       ovf;
   logic       busy;

   modport master (
      input  req, clr, ready,
      output y, valid, pend, ovf, busy
   );

   modport slave (
      output req, clr, ready,
      input  y, valid, pend, ovf, busy
   );
endinterface

// File: rtl/req_encoder_8to3.sv
// ---------------------------------------------------------------------------
// req_encoder_8to3
//   Captures up to 8 request lines into sticky pending flags and presents the
//   highest-priority pending index as a 3-bit code on a valid/ready handshake.
//   Ports:
//     clk        single clock, rising edge
//     rst        synchronous active-high reset
//     bus        req_encoder_8to3_if.master (req/clr/ready in; y/valid/pend/ovf/busy out)
//   Parameter:
//     LSB_FIRST  0 = bit 7 has highest priority, 1 = bit 0 has highest priority
// ---------------------------------------------------------------------------
module req_encoder_8to3 #(
   parameter bit LSB_FIRST = 1'b0
) (
   input  logic                      clk,
   input  logic                      rst,
   req_encoder_8to3_if.master        bus
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_HOLD = 1'b1;

   logic [0:0] state_q, state_d;
   logic [2:0] y_q, y_d;
   logic [7:0] pend_q, pend_d;
   logic       ovf_q, ovf_d;

   logic       valid;
   logic [7:0] acc;     // one-hot: presented code is being accepted
   logic [7:0] hit;     // request landed on a flag that is staying pending
   logic [7:0] avail;   // pending flags still eligible for presentation
   logic [2:0] sel;

   // valid is a direct decode of the state flop, so it is registered.
   assign valid = (state_q == ST_HOLD);

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_bit
         assign acc[gi]    = valid & bus.ready & (y_q == 3'(gi));
         // req wins over clr and acceptance so a new event is never lost.
         assign pend_d[gi] = bus.req[gi] | (pend_q[gi] & ~bus.clr[gi] & ~acc[gi]);
         assign hit[gi]    = bus.req[gi] & pend_q[gi] & ~acc[gi] & ~bus.clr[gi];
      end
   endgenerate

   // Selection works from the registered flags only; same-cycle requests are
   // presented at the earliest one cycle later.
   assign avail = pend_q & ~acc;
   assign ovf_d = ovf_q | (|hit);

   always_comb begin
      sel = 3'd0;
      for (int i = 0; i < 8; i++) begin
         // Later iterations override earlier ones, so the last set bit visited wins.
         if (LSB_FIRST) begin
            if (avail[7 - i]) sel = 3'(7 - i);
         end else begin
            if (avail[i]) sel = 3'(i);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      y_d     = y_q;
      case (state_q)
         ST_IDLE: begin
            if (|pend_q) begin
               y_d     = sel;
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            // y is frozen until accepted; a clr of the presented bit does not
            // withdraw it.
            if (bus.ready) begin
               if (|avail) begin
                  y_d = sel;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         y_q     <= 3'd0;
         pend_q  <= 8'd0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         y_q     <= y_d;
         pend_q  <= pend_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.y     = y_q;
   assign bus.valid = valid;
   assign bus.pend  = pend_q;
   assign bus.ovf   = ovf_q;
   assign bus.busy  = (|pend_q) | valid;

endmodule
